// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path: parity-mode encodings
//   used by the PARITY_MODE parameter and the receiver state encoding.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Synchronizes the asynchronous serial line, runs the bit-period counter
//   and produces one bit decision per bit period for the receive FSM.
//   Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 vote around the
//   bit mid-point, decision one cycle later).
// Ports:
//   clk_i        clock
//   srst_i       synchronous active-high reset
//   rxd_i        asynchronous serial input, idle high
//   clr_i        hold the bit-period counter at zero (FSM waiting for a frame)
//   rx_sync_o    synchronized line level
//   bit_valid_o  one-cycle pulse: bit_value_o holds the current bit decision
//   bit_value_o  sampled (or voted) bit value
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 48
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic rxd_i,
  input  logic clr_i,
  output logic rx_sync_o,
  output logic bit_valid_o,
  output logic bit_value_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      cnt_q  <= cnt_d;
    end
  end

  // The counter is zero on the first START cycle and then free-runs modulo
  // CLKS_PER_BIT, so every later bit lands on the same counter phase.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  assign rx_sync_o = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // Counter value H is the cycle just after the nominal mid-point, when the
  // samples at mid-1, mid and mid+1 are all available.
  localparam logic [CW-1:0] SAMPLE_AT = CW'(H);

  logic [1:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  assign bit_value_o = (sync_q[1] & hist_q[0]) |
                       (sync_q[1] & hist_q[1]) |
                       (hist_q[0] & hist_q[1]);
`else
  // Counter starts one cycle after cycle 0, so value H-1 is cycle H.
  localparam logic [CW-1:0] SAMPLE_AT = CW'(H - 1);

  assign bit_value_o = sync_q[1];
`endif

  assign bit_valid_o = !clr_i && (cnt_q == SAMPLE_AT);

endmodule

// File: rtl/uart_rx_speculative.sv
// uart_rx_speculative
//   Parametrised UART receiver feeding a speculative FIFO write port. The
//   word is written as soon as the last data bit is sampled; parity and stop
//   bits are checked afterwards and the write is committed or rolled back.
//   Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 bit voting, all
//   decisions one cycle later).
// Ports:
//   CLK288MHZ      sole clock
//   reset          synchronous active-high reset (shared with the FIFO)
//   uart_rxd_out   asynchronous serial line, idle high
//   dataOut        received word, valid with writeEn
//   writeEn        one-cycle speculative write strobe
//   commitWrite    one-cycle pulse: last speculative word is good
//   rollbackWrite  one-cycle pulse: discard last speculative word
//   frameErr       with rollback: a stop bit was low
//   parityErr      with rollback: parity mismatch
//   breakDet       with rollback: every data, parity and stop bit was low
//   busy           receiver not in IDLE
module uart_rx_speculative
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 48,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK288MHZ,
  input  logic                 reset,
  input  logic                 uart_rxd_out,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 writeEn,
  output logic                 commitWrite,
  output logic                 rollbackWrite,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 breakDet,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, dout_q, dout_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic stop_idx_q, stop_idx_d;
  logic par_q, par_d;          // running XOR of data (and parity) bits
  logic zero_q, zero_d;        // every bit after the start bit was low
  logic stop_ok_q, stop_ok_d;  // every stop bit so far was high
  logic we_q, we_d, cm_q, cm_d, rb_q, rb_d;
  logic fe_q, fe_d, pe_q, pe_d, bd_q, bd_d, busy_q, busy_d;

  logic rx_sync, bit_valid, bit_value, parity_ok;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk_i      (CLK288MHZ),
    .srst_i     (reset),
    .rxd_i      (uart_rxd_out),
    .clr_i      ((state_q == IDLE) || (state_q == BREAK_WAIT)),
    .rx_sync_o  (rx_sync),
    .bit_valid_o(bit_valid),
    .bit_value_o(bit_value)
  );

  assign parity_ok = (PARITY_MODE == PARITY_NONE) ||
                     (par_q == (PARITY_MODE == PARITY_ODD));

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    zero_d     = zero_q;
    stop_ok_d  = stop_ok_q;
    dout_d     = dout_q;
    we_d       = 1'b0;
    cm_d       = 1'b0;
    rb_d       = 1'b0;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    bd_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (bit_valid) begin
          if (bit_value) begin
            state_d = IDLE;  // glitch, not a start bit
          end else begin
            state_d    = DATA;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            par_d      = 1'b0;
            zero_d     = 1'b1;
            stop_ok_d  = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_valid) begin
          shreg_d[bit_idx_q] = bit_value;
          par_d  = par_q ^ bit_value;
          zero_d = zero_q & ~bit_value;
          if (bit_idx_q == LAST_DATA) begin
            we_d    = 1'b1;
            dout_d  = shreg_d;
            state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          par_d   = par_q ^ bit_value;
          zero_d  = zero_q & ~bit_value;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          stop_ok_d = stop_ok_q & bit_value;
          zero_d    = zero_q & ~bit_value;
          if (stop_idx_q == LAST_STOP) begin
            // Returning to IDLE at the stop mid-point leaves half a bit of
            // slack for a back-to-back start edge.
            if (parity_ok && stop_ok_d) begin
              cm_d    = 1'b1;
              state_d = IDLE;
            end else begin
              rb_d = 1'b1;
              pe_d = !parity_ok;
              fe_d = !stop_ok_d;
              if (zero_d) begin
                bd_d    = 1'b1;
                state_d = BREAK_WAIT;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      BREAK_WAIT: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK288MHZ) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      zero_q     <= 1'b0;
      stop_ok_q  <= 1'b0;
      dout_q     <= '0;
      we_q       <= 1'b0;
      cm_q       <= 1'b0;
      rb_q       <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      bd_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      zero_q     <= zero_d;
      stop_ok_q  <= stop_ok_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      cm_q       <= cm_d;
      rb_q       <= rb_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      bd_q       <= bd_d;
      busy_q     <= busy_d;
    end
  end

  assign dataOut       = dout_q;
  assign writeEn       = we_q;
  assign commitWrite   = cm_q;
  assign rollbackWrite = rb_q;
  assign frameErr      = fe_q;
  assign parityErr     = pe_q;
  assign breakDet      = bd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_speculative.sv
// tb_uart_rx_speculative
//   Directed bench: dut_a is 8N1, dut_b is 8E1, both at 48 clocks per bit.
module tb_uart_rx_speculative;

  localparam int CPB = 48;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int WE = 0, CM = 1, RB = 2, FE = 3, PE = 4, BD = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxa = 1'b1;
  logic rxb = 1'b1;

  logic [7:0] a_dout, b_dout;
  logic a_we, a_cm, a_rb, a_fe, a_pe, a_bd, a_busy;
  logic b_we, b_cm, b_rb, b_fe, b_pe, b_bd, b_busy;

  always #5 clk = ~clk;

  uart_rx_speculative #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)
  ) dut_a (
    .CLK288MHZ(clk), .reset(reset), .uart_rxd_out(rxa), .dataOut(a_dout),
    .writeEn(a_we), .commitWrite(a_cm), .rollbackWrite(a_rb),
    .frameErr(a_fe), .parityErr(a_pe), .breakDet(a_bd), .busy(a_busy)
  );

  uart_rx_speculative #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)
  ) dut_b (
    .CLK288MHZ(clk), .reset(reset), .uart_rxd_out(rxb), .dataOut(b_dout),
    .writeEn(b_we), .commitWrite(b_cm), .rollbackWrite(b_rb),
    .frameErr(b_fe), .parityErr(b_pe), .breakDet(b_bd), .busy(b_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: cumulative high-cycle counts plus cycle/data of the
  // most recent writeEn, commit and rollback.
  int a_cnt[6] = '{default: 0};
  int b_cnt[6] = '{default: 0};
  int a_s[6];
  int b_s[6];
  int a_we_cyc = 0, a_cm_cyc = 0, a_rb_cyc = 0;
  int b_we_cyc = 0, b_cm_cyc = 0, b_rb_cyc = 0;
  logic [7:0] a_we_data = '0, b_we_data = '0;

  always @(negedge clk) begin
    a_cnt[WE] <= a_cnt[WE] + (a_we ? 1 : 0);
    a_cnt[CM] <= a_cnt[CM] + (a_cm ? 1 : 0);
    a_cnt[RB] <= a_cnt[RB] + (a_rb ? 1 : 0);
    a_cnt[FE] <= a_cnt[FE] + (a_fe ? 1 : 0);
    a_cnt[PE] <= a_cnt[PE] + (a_pe ? 1 : 0);
    a_cnt[BD] <= a_cnt[BD] + (a_bd ? 1 : 0);
    b_cnt[WE] <= b_cnt[WE] + (b_we ? 1 : 0);
    b_cnt[CM] <= b_cnt[CM] + (b_cm ? 1 : 0);
    b_cnt[RB] <= b_cnt[RB] + (b_rb ? 1 : 0);
    b_cnt[FE] <= b_cnt[FE] + (b_fe ? 1 : 0);
    b_cnt[PE] <= b_cnt[PE] + (b_pe ? 1 : 0);
    b_cnt[BD] <= b_cnt[BD] + (b_bd ? 1 : 0);
    if (a_we) begin a_we_cyc <= cyc; a_we_data <= a_dout; end
    if (a_cm) a_cm_cyc <= cyc;
    if (a_rb) a_rb_cyc <= cyc;
    if (b_we) begin b_we_cyc <= cyc; b_we_data <= b_dout; end
    if (b_cm) b_cm_cyc <= cyc;
    if (b_rb) b_rb_cyc <= cyc;
  end

  int n_checks = 0;
  int n_errors = 0;
  int base = 0;  // absolute cycle number of frame cycle 0

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int k = 0; k < 6; k++) begin
      a_s[k] = a_cnt[k];
      b_s[k] = b_cnt[k];
    end
  endtask

  function automatic int da(input int k);
    return a_cnt[k] - a_s[k];
  endfunction

  function automatic int db(input int k);
    return b_cnt[k] - b_s[k];
  endfunction

  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
    logic [15:0] v;
    v      = '0;
    v[8:1] = d;
    v[9]   = stop;
    return v;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) rxb = v;
    else     rxa = v;
  endtask

  // Send n bits LSB first, CPB cycles each; optionally abandon the frame
  // (line back to idle) once frame cycle abort_at is reached.
  task automatic send_bits(input bit sel, input logic [15:0] bits, input int n,
                           input int abort_at);
    @(posedge clk); #1;
    base = cyc + 2;
    for (int i = 0; i < n * CPB; i++) begin
      if (abort_at >= 0 && (cyc - base) >= abort_at) break;
      drive(sel, bits[i / CPB]);
      @(posedge clk); #1;
    end
    drive(sel, 1'b1);
  endtask

  task automatic wait_rel(input int n);
    while (cyc < base + n) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_outs_a", 32'({a_dout, a_we, a_cm, a_rb, a_fe, a_pe, a_bd, a_busy}), 0);
    check("rst_outs_b", 32'({b_dout, b_we, b_cm, b_rb, b_fe, b_pe, b_bd, b_busy}), 0);
    idle(10);
    check("idle_busy", 32'(a_busy), 0);
    $display("reset: outputs checked");

    // ---- valid 8N1 frame 0xA5
    snap();
    send_bits(0, frame8(8'hA5, 1'b1), 10, -1);
    idle(2 * CPB);
    check("ok_we_cnt", da(WE), 1);
    check("ok_we_cyc", a_we_cyc - base, 409 + LAT);
    check("ok_data", 32'(a_we_data), 32'h0000_00A5);
    check("ok_cm_cnt", da(CM), 1);
    check("ok_cm_cyc", a_cm_cyc - base, 457 + LAT);
    check("ok_rb_cnt", da(RB), 0);
    check("ok_err_cnt", da(FE) + da(PE) + da(BD), 0);
    check("ok_busy", 32'(a_busy), 0);
    $display("frame 8N1 0xA5 stop=1 done");

    // ---- frame error: 0x3C with stop low
    snap();
    send_bits(0, frame8(8'h3C, 1'b0), 10, -1);
    idle(3 * CPB);
    check("fe_we_cnt", da(WE), 1);
    check("fe_data", 32'(a_we_data), 32'h0000_003C);
    check("fe_rb_cnt", da(RB), 1);
    check("fe_rb_lat", a_rb_cyc - a_we_cyc, CPB);
    check("fe_fe_cnt", da(FE), 1);
    check("fe_pe_cnt", da(PE), 0);
    check("fe_bd_cnt", da(BD), 0);
    check("fe_cm_cnt", da(CM), 0);
    $display("frame 8N1 0x3C stop=0 done");

    // ---- parity error: 8E1, 0x01 with parity bit 0
    snap();
    send_bits(1, 16'h0402, 11, -1);
    idle(3 * CPB);
    check("pe_we_cnt", db(WE), 1);
    check("pe_we_cyc", b_we_cyc - base, 409 + LAT);
    check("pe_data", 32'(b_we_data), 32'h0000_0001);
    check("pe_rb_cnt", db(RB), 1);
    check("pe_rb_lat", b_rb_cyc - b_we_cyc, 2 * CPB);
    check("pe_pe_cnt", db(PE), 1);
    check("pe_fe_cnt", db(FE), 0);
    check("pe_bd_cnt", db(BD), 0);
    check("pe_cm_cnt", db(CM), 0);
    $display("frame 8E1 0x01 parity=0 done");

    // ---- valid 8E1: 0x03 with parity bit 0
    snap();
    send_bits(1, 16'h0406, 11, -1);
    idle(3 * CPB);
    check("pok_data", 32'(b_we_data), 32'h0000_0003);
    check("pok_cm_cnt", db(CM), 1);
    check("pok_cm_lat", b_cm_cyc - b_we_cyc, 2 * CPB);
    check("pok_rb_cnt", db(RB), 0);
    $display("frame 8E1 0x03 parity=0 done");

    // ---- false start: 20-cycle glitch
    snap();
    @(posedge clk); #1;
    base = cyc + 2;
    rxa  = 1'b0;
    wait_rel(5);
    check("fs_busy_5", 32'(a_busy), 1);
    while (cyc < base + 18) begin @(posedge clk); #1; end
    rxa = 1'b1;
    wait_rel(24 + LAT);
    check("fs_busy_24", 32'(a_busy), 1);
    wait_rel(25 + LAT);
    check("fs_busy_25", 32'(a_busy), 0);
    idle(CPB);
    check("fs_strobes", da(WE) + da(CM) + da(RB), 0);
    $display("glitch 20 cycles done");

    // ---- break: 12 bit periods low
    snap();
    @(posedge clk); #1;
    base = cyc + 2;
    rxa  = 1'b0;
    wait_rel(500);
    check("brk_busy_low", 32'(a_busy), 1);
    check("brk_we_cnt", da(WE), 1);
    check("brk_data", 32'(a_we_data), 0);
    check("brk_rb_cnt", da(RB), 1);
    check("brk_fe_cnt", da(FE), 1);
    check("brk_bd_cnt", da(BD), 1);
    check("brk_pe_cnt", da(PE), 0);
    check("brk_cm_cnt", da(CM), 0);
    while (cyc < base - 2 + 12 * CPB) begin @(posedge clk); #1; end
    rxa = 1'b1;
    wait_rel(12 * CPB + 6);
    check("brk_busy_high", 32'(a_busy), 0);
    check("brk_we_hold", da(WE), 1);
    send_bits(0, frame8(8'h5A, 1'b1), 10, -1);
    idle(2 * CPB);
    check("brk_next_data", 32'(a_we_data), 32'h0000_005A);
    check("brk_next_cm", da(CM), 1);
    $display("break 12 bit periods then 0x5A done");

    // ---- reset in the middle of a 0x55 frame
    snap();
    send_bits(0, frame8(8'h55, 1'b1), 10, 200);
    check("mr_busy_200", 32'(a_busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mr_outs", 32'({a_dout, a_we, a_cm, a_rb, a_fe, a_pe, a_bd, a_busy}), 0);
    idle(3 * CPB);
    check("mr_strobes", da(WE) + da(CM) + da(RB), 0);
    send_bits(0, frame8(8'h55, 1'b1), 10, -1);
    idle(2 * CPB);
    check("mr_next_we", da(WE), 1);
    check("mr_next_data", 32'(a_we_data), 32'h0000_0055);
    check("mr_next_cm", da(CM), 1);
    check("mr_next_rb", da(RB), 0);
    $display("mid-frame reset then 0x55 done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
